// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - load/store front end for the 32-word negedge data memory
//
// Optional feature macro: MEM_CTRL_STATS_EN (adds saturating access counters).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (accepted only in IDLE)
//   req_write/req_addr/req_wdata/req_be  store flag, word address, data, byte enables
//   resp_valid/resp_ready           held response handshake
//   resp_rdata/resp_err             load data (0 for stores/errors), out-of-range flag
//   mem_enable/mem_write/mem_addr/mem_din  memory drive, changes only at posedge
//   mem_dout                        memory read data, updated on negedge
//   stat_rd/stat_wr/stat_rmw/stat_err  access counters (MEM_CTRL_STATS_EN only)

module mem_ctrl #(
  parameter int MEM_WORDS = 32,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_enable,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [15:0]       stat_rd,
  output logic [15:0]       stat_wr,
  output logic [15:0]       stat_rmw,
  output logic [15:0]       stat_err
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic req_oor;
  logic accept;

  assign req_oor = (req_addr >= ADDR_W'(MEM_WORDS));
  assign accept  = (state_q == S_IDLE) && req_valid;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          rdata_d = '0;
          err_d   = 1'b0;
          if (req_oor) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (!req_write) begin
            state_d = S_RD;
          end else if (req_be == 4'hF) begin
            state_d = S_WR;
          end else if (req_be == 4'h0) begin
            // Nothing to write: answer without touching the memory.
            state_d = S_RESP;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_RD: begin
        rdata_d = mem_dout;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        // Enabled lanes take the new data, the rest keep the word just read.
        for (int i = 0; i < 4; i++) begin
          merge_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_dout[8*i +: 8];
        end
        state_d = S_WR;
      end
      S_WR: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory drive is decoded from registered state only, so it moves at
  // posedge (stable for the memory's negedge) and drops at once on reset.
  always_comb begin
    mem_enable = (state_q == S_RD) || (state_q == S_RMW_RD) || (state_q == S_WR);
    mem_write  = (state_q == S_WR) && wr_q;
    mem_addr   = mem_enable ? addr_q : '0;
    mem_din    = '0;
    if (mem_write) begin
      mem_din = (be_q == 4'hF) ? wdata_q : merge_q;
    end
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

`ifdef MEM_CTRL_STATS_EN
  logic [15:0] stat_rd_q, stat_rd_d;
  logic [15:0] stat_wr_q, stat_wr_d;
  logic [15:0] stat_rmw_q, stat_rmw_d;
  logic [15:0] stat_err_q, stat_err_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counted on the accept edge; the WR that follows RMW_RD is not a new entry.
  always_comb begin
    stat_rd_d  = stat_rd_q;
    stat_wr_d  = stat_wr_q;
    stat_rmw_d = stat_rmw_q;
    stat_err_d = stat_err_q;
    if (accept) begin
      if (req_oor) begin
        stat_err_d = sat_inc(stat_err_q);
      end else if (!req_write) begin
        stat_rd_d = sat_inc(stat_rd_q);
      end else if (req_be == 4'hF) begin
        stat_wr_d = sat_inc(stat_wr_q);
      end else if (req_be != 4'h0) begin
        stat_rmw_d = sat_inc(stat_rmw_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_q  <= '0;
      stat_wr_q  <= '0;
      stat_rmw_q <= '0;
      stat_err_q <= '0;
    end else begin
      stat_rd_q  <= stat_rd_d;
      stat_wr_q  <= stat_wr_d;
      stat_rmw_q <= stat_rmw_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_rd  = stat_rd_q;
  assign stat_wr  = stat_wr_q;
  assign stat_rmw = stat_rmw_q;
  assign stat_err = stat_err_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Request/response front end that sits directly upstream of the 32-word negedge-clocked data memory and drives its enable/write/addr/din port.
- Accepts word load/store requests from the core over a valid/ready handshake.
- Performs byte-enabled stores as read-modify-write.
- Returns load data and error status on a held response channel.

Parameters:
- MEM_WORDS, 32, number of implemented memory words; word addresses >= MEM_WORDS are out of range.
- ADDR_W, 24, width of req_addr and mem_addr (word address).
- DATA_W, 32, data width; must be 32 (4 byte lanes).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_be  in  4  byte enables for stores; bit i = bits [8i+7:8i]; ignored for loads.
- resp_valid  out  1  response available.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  DATA_W  load data; 0 for stores and errors.
- resp_err  out  1  address out of range.
- mem_enable  out  1  to memory.
- mem_write  out  1  to memory.
- mem_addr  out  ADDR_W  to memory.
- mem_din  out  DATA_W  to memory.
- mem_dout  in  DATA_W  from memory; updated on negedge clk.

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_enable=0, mem_write=0, mem_addr=0, mem_din=0, all latched request fields 0.
- Timing contract: mem_* outputs change only at posedge, so they are stable at the intervening negedge. The memory acts at that negedge. mem_dout is captured at the following posedge.
- States:
  - IDLE: req_ready=1, mem_enable=0. On req_valid, latch write/addr/wdata/be, then:
    - addr >= MEM_WORDS -> RESP with err=1; no memory access.
    - load -> RD.
    - store with be=4'b1111 -> WR.
    - store with be=4'b0000 -> RESP; no memory access.
    - other store -> RMW_RD.
  - RD: mem_enable=1, mem_write=0, mem_addr=latched addr. Next posedge: resp_rdata<=mem_dout, go RESP.
  - RMW_RD: same drive as RD. Next posedge: merge register <= per-byte (be ? wdata : mem_dout), go WR.
  - WR: mem_enable=1, mem_write=1, mem_addr=latched addr, mem_din = wdata (full) or merge register (partial). Next posedge -> RESP.
  - RESP: resp_valid=1, outputs held stable. When resp_ready=1 at posedge -> IDLE.
- req_ready is 0 in every state except IDLE; no back-to-back acceptance from RESP in the same cycle.
- Latency from accept edge to resp_valid: load 2 cycles, full store 2, partial store 3, error or be=0 store 1.
- resp_rdata=0 and resp_err=0 on every non-error store response.
- Reset mid-operation: state returns to IDLE asynchronously and mem_enable drops immediately. A WR whose negedge has not yet occurred is suppressed. The pending response is discarded.
- req_* changes while not accepted are ignored. Latched values are used throughout the access.

Optional Feature:
- MEM_CTRL_STATS_EN
- Defined: adds outputs stat_rd, stat_wr, stat_rmw, stat_err (each 16 bits).
  - On each entry to RD, WR-from-IDLE, RMW_RD, or error-RESP respectively, the matching counter increments by 1.
  - Counters saturate at 16'hFFFF and reset to 0 on rst_n.
  - The WR entered from RMW_RD counts only in stat_rmw.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Full store addr=5 data=32'hDEADBEEF be=1111, then load addr=5 -> resp_valid 2 cycles after each accept; load resp_rdata=32'hDEADBEEF, resp_err=0.
- Word 7 holds 32'h11223344; partial store be=0101 data=32'hAABBCCDD, then load addr=7 -> 32'h11BB33DD; store response arrives 3 cycles after accept.
- Load addr=32 (MEM_WORDS=32) -> resp_err=1, resp_rdata=0 after 1 cycle; mem_enable never asserted.
- Hold resp_ready=0 for 4 cycles after a load -> resp_valid and resp_rdata stay constant, req_ready=0; next request accepted only after a resp_ready handshake and return to IDLE.
- Assert rst_n=0 in WR before the negedge, store addr=3 data=1 -> mem_enable=0 immediately, word 3 unchanged on later load, resp_valid=0.
- With MEM_CTRL_STATS_EN: 2 loads, 1 full store, 1 partial store, 1 error -> stat_rd=2, stat_wr=1, stat_rmw=1, stat_err=1.
